// File: rtl/sgt_stream_pkg.sv
// rtl/sgt_stream_pkg.sv - shared op encodings and reset-value helper for the stream tracker
package sgt_stream_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_GT = 3'd0;
  localparam logic [OP_W-1:0] OP_GE = 3'd1;
  localparam logic [OP_W-1:0] OP_LT = 3'd2;
  localparam logic [OP_W-1:0] OP_LE = 3'd3;
  localparam logic [OP_W-1:0] OP_EQ = 3'd4;
  localparam logic [OP_W-1:0] OP_NE = 3'd5;

  // Smallest representable value: the frame max restarts from here.
  // Returned 64 bits wide; callers truncate to their WIDTH (WIDTH <= 64).
  function automatic logic [63:0] min_val(input int width, input bit signed_mode);
    return signed_mode ? (64'd1 << (width - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/sgt_cmp_core.sv
// rtl/sgt_cmp_core.sv - combinational greater-than / equal core, signed or unsigned
module sgt_cmp_core #(
  parameter int WIDTH  = 2,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq
);

  // Single magnitude compare shared by every derived op
  always_comb begin
    eq = (a == b);
    if (SIGNED) begin
      gt = ($signed(a) > $signed(b));
    end else begin
      gt = (a > b);
    end
  end

endmodule

// File: rtl/sgt_stream_tracker.sv
// rtl/sgt_stream_tracker.sv - streaming comparator with per-frame running max and beat count
module sgt_stream_tracker
  import sgt_stream_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter bit SIGNED = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [OP_W-1:0]  op,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             O,
  output logic             op_err,
  output logic             out_last,
  output logic [WIDTH-1:0] frame_max,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [WIDTH-1:0] MAX_RST = WIDTH'(min_val(WIDTH, SIGNED));
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic             in_frame;
  logic             accept;
  logic             op_gt, op_eq;
  logic             max_gt, max_eq;
  logic             res, err;
  logic [WIDTH-1:0] nxt_max;
  logic [CNT_W-1:0] nxt_cnt;

  // No skid buffer: a stalled output blocks the input directly
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  sgt_cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_op (
    .a  (I0),
    .b  (I1),
    .gt (op_gt),
    .eq (op_eq)
  );

  // The published frame_max doubles as the running accumulator while in_frame=1
  sgt_cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_max (
    .a  (I0),
    .b  (frame_max),
    .gt (max_gt),
    .eq (max_eq)
  );

  // Decode the op from the shared gt/eq pair and compute the next frame statistics
  always_comb begin
    res     = 1'b0;
    err     = 1'b0;
    nxt_max = frame_max;
    nxt_cnt = frame_cnt;
    case (op)
      OP_GT:   res = op_gt;
      OP_GE:   res = op_gt | op_eq;
      OP_LT:   res = !op_gt & !op_eq;
      OP_LE:   res = !op_gt;
      OP_EQ:   res = op_eq;
      OP_NE:   res = !op_eq;
      default: err = 1'b1;
    endcase
    if (!in_frame) begin
      nxt_max = I0;
      nxt_cnt = CNT_W'(1);
    end else begin
      // Strictly greater only: an equal sample keeps the stored max
      if (max_gt && !max_eq) begin
        nxt_max = I0;
      end
      if (frame_cnt != CNT_SAT) begin
        nxt_cnt = frame_cnt + CNT_W'(1);
      end
    end
  end

  // Single output register stage plus frame-open flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      O         <= 1'b0;
      op_err    <= 1'b0;
      out_last  <= 1'b0;
      frame_max <= MAX_RST;
      frame_cnt <= '0;
      in_frame  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      O         <= res;
      op_err    <= err;
      out_last  <= last;
      frame_max <= nxt_max;
      frame_cnt <= nxt_cnt;
      in_frame  <= !last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sgt_stream_tracker.sv
// tb/tb_sgt_stream_tracker.sv - self-checking bench for sgt_stream_tracker
module tb_sgt_stream_tracker;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       in_valid;
  logic [1:0] I0, I1;
  logic [2:0] op;
  logic       last;
  logic       out_ready;

  logic       in_ready_s, out_valid_s, O_s, op_err_s, out_last_s;
  logic [1:0] frame_max_s;
  logic [7:0] frame_cnt_s;
  logic       in_ready_u, out_valid_u, O_u, op_err_u, out_last_u;
  logic [1:0] frame_max_u;
  logic [7:0] frame_cnt_u;
  logic       in_ready_c, out_valid_c, O_c, op_err_c, out_last_c;
  logic [1:0] frame_max_c;
  logic [1:0] frame_cnt_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       o;
    logic       err;
    logic       lst;
    logic [1:0] mx;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  bit   m_in_frame;
  int   m_max;
  int   m_cnt;

  always #5 CLK = ~CLK;

  sgt_stream_tracker #(.WIDTH(2), .SIGNED(1'b1), .CNT_W(8)) u_s (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready_s),
    .I0(I0), .I1(I1), .op(op), .last(last), .out_valid(out_valid_s),
    .out_ready(out_ready), .O(O_s), .op_err(op_err_s), .out_last(out_last_s),
    .frame_max(frame_max_s), .frame_cnt(frame_cnt_s)
  );

  sgt_stream_tracker #(.WIDTH(2), .SIGNED(1'b0), .CNT_W(8)) u_u (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready_u),
    .I0(I0), .I1(I1), .op(op), .last(last), .out_valid(out_valid_u),
    .out_ready(out_ready), .O(O_u), .op_err(op_err_u), .out_last(out_last_u),
    .frame_max(frame_max_u), .frame_cnt(frame_cnt_u)
  );

  sgt_stream_tracker #(.WIDTH(2), .SIGNED(1'b1), .CNT_W(2)) u_c (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready_c),
    .I0(I0), .I1(I1), .op(op), .last(last), .out_valid(out_valid_c),
    .out_ready(out_ready), .O(O_c), .op_err(op_err_c), .out_last(out_last_c),
    .frame_max(frame_max_c), .frame_cnt(frame_cnt_c)
  );

  function automatic int sx(input logic [1:0] x);
    return x[1] ? int'(x) - 4 : int'(x);
  endfunction

  // returns {op_err, O}
  function automatic logic [1:0] model_cmp(input int a, input int b, input logic [2:0] o);
    case (o)
      3'd0:    return {1'b0, a >  b};
      3'd1:    return {1'b0, a >= b};
      3'd2:    return {1'b0, a <  b};
      3'd3:    return {1'b0, a <= b};
      3'd4:    return {1'b0, a == b};
      3'd5:    return {1'b0, a != b};
      default: return 2'b10;
    endcase
  endfunction

  task automatic do_reset();
    RESET     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    RESET      = 1'b0;
    m_in_frame = 1'b0;
    m_max      = -2;
    m_cnt      = 0;
    sb.delete();
  endtask

  // One clock: drive, settle, pop any draining beat, push any accepted beat
  task automatic cycle(input logic v, input logic [1:0] a, input logic [1:0] b,
                       input logic [2:0] o, input logic l, input logic rdy);
    exp_t e;
    logic [1:0] r;
    in_valid  = v;
    I0        = a;
    I1        = b;
    op        = o;
    last      = l;
    out_ready = rdy;
    #1;
    if (out_valid_s && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: out beat %b/%b/%b/%0d/%0d with nothing expected",
                 O_s, op_err_s, out_last_s, frame_max_s, frame_cnt_s);
      end else begin
        e = sb.pop_front();
        if ({O_s, op_err_s, out_last_s, frame_max_s, frame_cnt_s} !== {e.o, e.err, e.lst, e.mx, e.cnt}) begin
          errors++;
          $display("FAIL sb_beat: got O=%b err=%b last=%b max=%0d cnt=%0d, want O=%b err=%b last=%b max=%0d cnt=%0d",
                   O_s, op_err_s, out_last_s, frame_max_s, frame_cnt_s, e.o, e.err, e.lst, e.mx, e.cnt);
        end
      end
    end
    if (v && in_ready_s) begin
      r = model_cmp(sx(a), sx(b), o);
      if (!m_in_frame) begin
        m_max = sx(a);
        m_cnt = 1;
      end else begin
        if (sx(a) > m_max) m_max = sx(a);
        if (m_cnt < 255) m_cnt++;
      end
      m_in_frame = !l;
      e.o   = r[0];
      e.err = r[1];
      e.lst = l;
      e.mx  = 2'(m_max);
      e.cnt = 8'(m_cnt);
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b1);
    checks++;
    if (sb.size() != 0 || out_valid_s !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d out_valid=%b, want 0 and 0", sb.size(), out_valid_s);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid_s, O_s, op_err_s, out_last_s, frame_cnt_s, frame_max_s} !== {4'b0000, 8'd0, 2'b10}) begin
      errors++;
      $display("FAIL reset_signed: got v=%b O=%b err=%b last=%b cnt=%0d max=%b, want zeros and max=10",
               out_valid_s, O_s, op_err_s, out_last_s, frame_cnt_s, frame_max_s);
    end
    checks++;
    if (frame_max_u !== 2'b00 || out_valid_u !== 1'b0 || in_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_unsigned: got max=%b v=%b in_ready=%b, want 00 0 1", frame_max_u, out_valid_u, in_ready_s);
    end
  endtask

  task automatic test_signed_cmp();
    do_reset();
    cycle(1'b1, 2'b01, 2'b10, 3'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid_s !== 1'b1 || O_s !== 1'b1) begin
      errors++;
      $display("FAIL signed_gt: got v=%b O=%b, want 1 1", out_valid_s, O_s);
    end
    cycle(1'b1, 2'b01, 2'b10, 3'd3, 1'b1, 1'b1);
    checks++;
    if (O_s !== 1'b0) begin
      errors++;
      $display("FAIL signed_le: got O=%b, want 0", O_s);
    end
    drain();
  endtask

  task automatic test_unsigned();
    do_reset();
    cycle(1'b1, 2'b01, 2'b10, 3'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid_u !== 1'b1 || O_u !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_gt: got v=%b O=%b, want 1 0", out_valid_u, O_u);
    end
    cycle(1'b1, 2'b11, 2'b11, 3'd4, 1'b0, 1'b1);
    checks++;
    if (O_u !== 1'b1 || op_err_u !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_eq: got O=%b err=%b, want 1 0", O_u, op_err_u);
    end
    cycle(1'b1, 2'b00, 2'b01, 3'd6, 1'b1, 1'b1);
    checks++;
    if (O_u !== 1'b0 || op_err_u !== 1'b1 || frame_cnt_u !== 8'd3 || frame_max_u !== 2'b11) begin
      errors++;
      $display("FAIL unsigned_reserved: got O=%b err=%b cnt=%0d max=%b, want 0 1 3 11",
               O_u, op_err_u, frame_cnt_u, frame_max_u);
    end
    drain();
  endtask

  task automatic test_frame();
    logic [1:0] seq  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] emax [4] = '{2'b10, 2'b11, 2'b01, 2'b01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, seq[i], 2'b00, 3'd1, (i == 3), 1'b1);
      checks++;
      if (frame_max_s !== emax[i] || frame_cnt_s !== 8'(i + 1) || out_last_s !== (i == 3)) begin
        errors++;
        $display("FAIL frame_beat%0d: got max=%b cnt=%0d last=%b, want max=%b cnt=%0d last=%b",
                 i, frame_max_s, frame_cnt_s, out_last_s, emax[i], i + 1, (i == 3));
      end
    end
    cycle(1'b1, 2'b00, 2'b00, 3'd4, 1'b1, 1'b1);
    checks++;
    if (frame_cnt_s !== 8'd1 || frame_max_s !== 2'b00 || out_last_s !== 1'b1) begin
      errors++;
      $display("FAIL frame_restart: got cnt=%0d max=%b last=%b, want 1 00 1", frame_cnt_s, frame_max_s, out_last_s);
    end
    drain();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'b01, 2'b00, 3'd0, (i == 4), 1'b1);
      checks++;
      if (frame_cnt_c !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
        errors++;
        $display("FAIL sat_cnt%0d: got %0d, want %0d", i, frame_cnt_c, (i < 3) ? i + 1 : 3);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [13:0] snap;
    do_reset();
    cycle(1'b1, 2'b01, 2'b00, 3'd0, 1'b0, 1'b1);
    snap = {O_s, op_err_s, out_last_s, frame_max_s, frame_cnt_s, out_valid_s};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'($urandom), 2'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      checks++;
      if (in_ready_s !== 1'b0 || {O_s, op_err_s, out_last_s, frame_max_s, frame_cnt_s, out_valid_s} !== snap) begin
        errors++;
        $display("FAIL stall%0d: got in_ready=%b fields=%h, want 0 and %h", i, in_ready_s,
                 {O_s, op_err_s, out_last_s, frame_max_s, frame_cnt_s, out_valid_s}, snap);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'($urandom), 2'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0), 1'b1);
      checks++;
      if (out_valid_s !== 1'b1 || sb.size() != 1) begin
        errors++;
        $display("FAIL stream%0d: got out_valid=%b pending=%0d, want 1 and 1", i, out_valid_s, sb.size());
      end
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0), 1'($urandom));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 2'b01, 2'b00, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (out_valid_s !== 1'b0 || frame_cnt_s !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b cnt=%0d, want 0 0", out_valid_s, frame_cnt_s);
    end
    cycle(1'b1, 2'b10, 2'b00, 3'd0, 1'b1, 1'b1);
    checks++;
    if (frame_max_s !== 2'b10 || frame_cnt_s !== 8'd1 || out_last_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_newframe: got max=%b cnt=%0d last=%b, want 10 1 1", frame_max_s, frame_cnt_s, out_last_s);
    end
    drain();
  endtask

  initial begin
    RESET     = 1'b1;
    in_valid  = 1'b0;
    I0        = '0;
    I1        = '0;
    op        = '0;
    last      = 1'b0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_signed_cmp();
    test_unsigned();
    test_frame();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgt_stream_tracker.md
Name: sgt_stream_tracker

Overview:
- Sequential successor to the 2-bit signed greater-than primitive.
- Streaming comparator with a valid/ready handshake, widened to any WIDTH.
- Supports a run-time op select (GT/GE/LT/LE/EQ/NE) and signed or unsigned interpretation.
- Adds a per-frame running-maximum tracker and beat counter on I0.
- Sits between a sample producer and downstream threshold and peak logic in mantle datapaths.

Parameters:
- WIDTH, 2, operand width in bits (>=1).
- SIGNED, 1, 1 = two's-complement compare and max; 0 = unsigned.
- CNT_W, 8, width of the per-frame beat counter.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- I0  input  WIDTH  left operand; also the sample tracked for the frame max.
- I1  input  WIDTH  right operand.
- op  input  3  compare op: 0 GT, 1 GE, 2 LT, 3 LE, 4 EQ, 5 NE, 6-7 reserved.
- last  input  1  marks the final beat of a frame.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- O  output  1  compare result for the beat.
- op_err  output  1  beat carried a reserved op.
- out_last  output  1  registered copy of last.
- frame_max  output  WIDTH  running max of I0 in the frame, including this beat.
- frame_cnt  output  CNT_W  beats in the frame so far, including this beat; saturating.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high, sampled on the CLK rising edge.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output drain = out_valid & out_ready.
  - in_ready = !out_valid | out_ready. This is a combinational pass-through of out_ready; there is no skid buffer.
  - Single output register stage; latency is exactly 1 cycle from accept to out_valid.
  - While out_valid=1 and out_ready=0, all output fields hold stable and in_ready=0.
  - Accept and drain in the same cycle: the new beat replaces the old one and out_valid stays 1. Full throughput is 1 beat per cycle.
  - Drain with no accept: out_valid goes to 0 next cycle.
- Compare:
  - Comparison uses $signed semantics when SIGNED=1 and unsigned when SIGNED=0.
  - Results are derived from a shared gt/eq pair: GE = gt|eq, LT = !gt&!eq, LE = !gt, NE = !eq.
  - Reserved op (6-7): O=0, op_err=1. Tracking still updates.
- Frame tracking:
  - Internal in_frame flag is 0 at reset and after an accepted beat with last=1.
  - First accepted beat of a frame: frame_max = I0, frame_cnt = 1.
  - Later beats: frame_max = I0 only if I0 > stored max (strictly, same signedness as the compare); equal values leave it unchanged.
  - frame_cnt increments by 1 per beat and saturates at 2^CNT_W-1; it does not wrap.
  - An accepted beat with last=1 publishes the final frame_max and frame_cnt with out_last=1, then clears the accumulator for the next beat.
  - A single-beat frame is legal: frame_max = I0, frame_cnt = 1, out_last = 1.
- Reset values:
  - out_valid=0, O=0, op_err=0, out_last=0, frame_cnt=0, in_frame=0.
  - frame_max = most-negative value (SIGNED=1: 1 followed by zeros) or 0 (SIGNED=0).
  - Reset mid-frame discards the partial frame and any pending output beat; the first beat after reset starts a new frame.
- Undriven operands while in_valid=0 have no effect on state.

Decomposition:
- Shared package sgt_stream_pkg holds:
  - the op encoding constants (OP_GT..OP_NE) and the OP_W=3 constant;
  - a function returning the reset/minimum value for a given WIDTH and SIGNED.
- One natural sub-module, sgt_cmp_core: combinational, parametrised by WIDTH and SIGNED, outputs gt and eq. It is instantiated twice: once for I0 vs I1, once for I0 vs stored max.

Test Plan:
- WIDTH=2, SIGNED=1, out_ready=1: I0=2'b01, I1=2'b10, op=GT -> next cycle out_valid=1, O=1. Same beat with op=LE -> O=0.
- WIDTH=2, SIGNED=0: I0=2'b01, I1=2'b10, op=GT -> O=0. op=EQ with I0=I1=2'b11 -> O=1. op=6 -> O=0, op_err=1.
- Frame over SIGNED WIDTH=2: I0 sequence -2, -1, 1, 0, last on the 4th beat. Expected frame_max per beat: -2, -1, 1, 1. Expected frame_cnt: 1, 2, 3, 4. out_last=1 only on beat 4; the next beat starts at frame_cnt=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable for those cycles.
  - Release -> one beat per cycle with none lost or duplicated (scoreboard checks 10 random beats).
- Reset mid-frame: 2 beats (I0=1, 0), assert RESET 1 cycle -> out_valid=0, frame_cnt=0. Next beat I0=-2 with last -> frame_max=-2, frame_cnt=1.
- CNT_W=2, 5-beat frame -> frame_cnt sequence 1, 2, 3, 3, 3.
